// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier on operand magnitudes with final sign fix-up.
// Optional early termination when the remaining multiplier is zero: define SEQ_MULT_EARLY_TERM_EN.
module seq_multiplier #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 ovr
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  state_t             state_next;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     sign_ext;
  logic               neg;
  logic               sgn;
  logic               last_iter;
  logic               ovr_next;

  // Magnitude of the most negative value wraps to itself, which reads correctly as unsigned.
  assign mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b = (is_signed && b[WIDTH-1]) ? -b : b;

  assign result   = neg ? -acc : acc;
  assign sign_ext = result[2*WIDTH-1:WIDTH-1];
  assign ovr_next = sgn ? !((sign_ext == '0) || (sign_ext == '1))
                        : (result[2*WIDTH-1:WIDTH] != '0);

  assign busy = (state != IDLE);

  always_comb begin
    last_iter = (cnt == CNT_W'(WIDTH - 1));
`ifdef SEQ_MULT_EARLY_TERM_EN
    if (mplier[WIDTH-1:1] == '0) begin
      last_iter = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_iter) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      sgn     <= 1'b0;
      product <= '0;
      ovr     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= '0;
            cnt    <= '0;
            neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            sgn    <= is_signed;
          end
        end
        RUN: begin
          // The multiplicand is pre-shifted each step so it always sits at the iteration index.
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        FIX: begin
          product <= result;
          ovr     <= ovr_next;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
